dekatron_step_driver: RTL and testbench
=======================================

// Module: dekatron_step_driver
// PURPOSE
//  Pulse-train transmitter for one dekatron tube (DekatronV2 cathode model or real tube driver).
//  Takes a one-hot target digit and emits active-low PulseRight_n/PulseLeft_n step pulses by shortest path.
//  Closes the loop on the tube's Out/Ready after every step; reports Done or Error.
//  Sits between the sequencer (IP/AP/data counters) and each tube, one instance per tube.
// PARAMETERS
//  PULSE_W    4   clocks a step pulse is held low (>=1)
//  SETTLE_W   4   min clocks after pulse release before Ready is sampled (>=1)
//  TIMEOUT    64  max clocks in SETTLE waiting for Ready=1 before Error (> SETTLE_W)
//  MAX_STEPS  6   pulses allowed per request before Error (shortest path needs <=5)
// PORTS
//  Clk           in   1   system clock, all state on posedge
//  Rst_n         in   1   asynchronous active-low reset
//  Start         in   1   request: latch Target and move; ignored while Busy=1
//  Abort         in   1   synchronous cancel of a running request
//  Target        in   10  one-hot target digit (bit n = digit n)
//  Current       in   10  one-hot tube state (tube Out)
//  Ready         in   1   tube glow on a main cathode and no pulse active
//  PulseRight_n  out  1   active-low step +1 (registered)
//  PulseLeft_n   out  1   active-low step -1 (registered)
//  Busy          out  1   request in progress
//  Done          out  1   one-cycle strobe: Current==Target reached
//  Error         out  1   sticky fault flag
// BEHAVIOUR
//  Reset (async, Rst_n=0): PulseRight_n=1, PulseLeft_n=1, Busy=0, Done=0, Error=0, step cnt=0, state IDLE.
//  States: IDLE, CHECK, PULSE, SETTLE, DONE, ERR.
//  IDLE: Start=1 -> latch Target, clear Error, step cnt=0, Busy=1, go CHECK.
//  CHECK (1 clk): Target or Current not exactly one bit set -> ERR.
//   Current==latched Target -> DONE. step cnt==MAX_STEPS -> ERR.
//   Else: d=(t-c) mod 10 on 4-bit indices; d<=5 -> right, d>=6 -> left (tie d=5 goes right).
//   step cnt++, go PULSE.
//  PULSE: selected _n output low for exactly PULSE_W clocks, then both high, go SETTLE.
//  SETTLE: wait SETTLE_W clocks, then first clock with Ready=1 -> CHECK.
//   Cycle count since SETTLE entry reaches TIMEOUT without that -> ERR.
//  DONE: Done=1 for exactly one clock, Busy=0 from same clock, -> IDLE.
//  ERR: Error=1, Busy=0, pulses high, -> IDLE; Error held until next accepted Start or reset.
//  Abort=1 in any busy state: next clock both pulses high, Busy=0, -> IDLE, no Done, Error unchanged.
//  Abort beats Start in the same cycle.
//  PulseRight_n and PulseLeft_n are never low together; outputs are straight from flops (glitch-free).
//  Already-at-target latency: Start sampled at edge k -> Done high for the cycle after edge k+2.
//  Per step: PULSE_W + max(SETTLE_W, Ready delay) + 1 clocks.
//  Wrap-around: 9->0 is one right pulse; 0->9 is one left pulse.
//  Target changes while Busy have no effect (latched copy used).
// TESTING (bench drives a DekatronV2 model from the pulse outputs)
//  1 Current=d0, Start Target=d3 -> 3 PulseRight_n lows of 4 clk each, PulseLeft_n stays 1.
//    Then one Done strobe, Current=d3.
//  2 d2->d8 -> 4 PulseLeft_n pulses, Done.
//    d0->d5 (tie) -> 5 right pulses.
//    d9->d0 -> 1 right pulse.
//  3 d4->d4 -> no pulses; Done exactly 2 clocks after Start sampled.
//  4 Target=10'b0 or 10'b0000010010 -> Error=1 after CHECK, no pulse.
//    Next valid Start clears Error.
//  5 Ready forced 0 after first pulse -> Error at SETTLE entry+64, pulses high, Busy=0.
//  6 Abort in 2nd PULSE clock -> pulse high next clk, Busy=0, no Done.
//    Rst_n low mid-SETTLE -> all outputs at reset values immediately.

Source files
------------

// File: rtl/dekatron_step_driver.sv
// Step-pulse driver for one dekatron tube: walks the glow to a one-hot target by the
// shortest path, checking the tube's Out/Ready after each step; reports Done or Error.
module dekatron_step_driver #(
  parameter int PULSE_W   = 4,
  parameter int SETTLE_W  = 4,
  parameter int TIMEOUT   = 64,
  parameter int MAX_STEPS = 6
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic [9:0] i_target,
  input  logic [9:0] i_current,
  input  logic       i_ready,
  output logic       o_pulse_right_n,
  output logic       o_pulse_left_n,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_PULSE, S_SETTLE, S_DONE, S_ERR} state_t;

  localparam int CNT_MAX = (TIMEOUT > PULSE_W) ? TIMEOUT : PULSE_W;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int SW      = $clog2(MAX_STEPS + 1);

  function automatic logic is_onehot(input logic [9:0] v);
    return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
  endfunction

  function automatic logic [3:0] to_index(input logic [9:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 10; i++)
      if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  state_t          r_state;
  logic [9:0]      r_target;
  logic [CW-1:0]   r_cnt;
  logic [SW-1:0]   r_steps;
  logic            r_dir_right;
  logic            r_pulse_right_n;
  logic            r_pulse_left_n;
  logic            r_busy;
  logic            r_done;
  logic            r_error;

  state_t          w_state_next;
  logic [9:0]      w_target_next;
  logic [CW-1:0]   w_cnt_next;
  logic [SW-1:0]   w_steps_next;
  logic            w_dir_next;
  logic            w_pulse_right_n_next;
  logic            w_pulse_left_n_next;
  logic            w_busy_next;
  logic            w_done_next;
  logic            w_error_next;

  logic [3:0]      w_t_idx;
  logic [3:0]      w_c_idx;
  logic [3:0]      w_diff;
  logic            w_go_right;
  logic            w_valid;
  logic            w_at_target;

  assign w_t_idx     = to_index(r_target);
  assign w_c_idx     = to_index(i_current);
  // Modulo-16 wrap of (t + 10 - c) still yields the correct 1..9 distance.
  assign w_diff      = (w_t_idx >= w_c_idx) ? (w_t_idx - w_c_idx) : (w_t_idx + 4'd10 - w_c_idx);
  assign w_go_right  = (w_diff <= 4'd5);
  assign w_valid     = is_onehot(r_target) && is_onehot(i_current);
  assign w_at_target = (i_current == r_target);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_target        <= '0;
      r_cnt           <= '0;
      r_steps         <= '0;
      r_dir_right     <= 1'b0;
      r_pulse_right_n <= 1'b1;
      r_pulse_left_n  <= 1'b1;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_error         <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_target        <= w_target_next;
      r_cnt           <= w_cnt_next;
      r_steps         <= w_steps_next;
      r_dir_right     <= w_dir_next;
      r_pulse_right_n <= w_pulse_right_n_next;
      r_pulse_left_n  <= w_pulse_left_n_next;
      r_busy          <= w_busy_next;
      r_done          <= w_done_next;
      r_error         <= w_error_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state != S_IDLE && i_abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (i_start && !i_abort) w_state_next = S_CHECK;
        S_CHECK: begin
          if (!w_valid)                         w_state_next = S_ERR;
          else if (w_at_target)                 w_state_next = S_DONE;
          else if (r_steps == SW'(MAX_STEPS))   w_state_next = S_ERR;
          else                                  w_state_next = S_PULSE;
        end
        S_PULSE:  if (r_cnt == CW'(PULSE_W - 1)) w_state_next = S_SETTLE;
        S_SETTLE: begin
          if (r_cnt >= CW'(SETTLE_W - 1) && i_ready) w_state_next = S_CHECK;
          else if (r_cnt == CW'(TIMEOUT - 1))        w_state_next = S_ERR;
        end
        S_DONE:   w_state_next = S_IDLE;
        S_ERR:    w_state_next = S_IDLE;
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_target_next = r_target;
    w_steps_next  = r_steps;
    w_dir_next    = r_dir_right;
    w_cnt_next    = '0;
    w_busy_next   = r_busy;
    w_done_next   = 1'b0;
    w_error_next  = r_error;

    if (r_state == S_IDLE && w_state_next == S_CHECK) begin
      w_target_next = i_target;
      w_steps_next  = '0;
      w_busy_next   = 1'b1;
      w_error_next  = 1'b0;
    end
    if (r_state == S_CHECK && w_state_next == S_PULSE) begin
      w_steps_next = r_steps + 1'b1;
      w_dir_next   = w_go_right;
    end
    if ((r_state == S_PULSE || r_state == S_SETTLE) && w_state_next == r_state)
      w_cnt_next = r_cnt + 1'b1;
    if (r_state != S_IDLE && w_state_next == S_IDLE)
      w_busy_next = 1'b0;
    if (r_state == S_DONE && !i_abort)
      w_done_next = 1'b1;
    if (r_state == S_ERR && !i_abort)
      w_error_next = 1'b1;

    // Pulses are registered from the next state so they can never be low together.
    w_pulse_right_n_next = !(w_state_next == S_PULSE && w_dir_next);
    w_pulse_left_n_next  = !(w_state_next == S_PULSE && !w_dir_next);
  end

  assign o_pulse_right_n = r_pulse_right_n;
  assign o_pulse_left_n  = r_pulse_left_n;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_error         = r_error;

endmodule

// File: tb/tb_dekatron_step_driver.sv
// Bench for dekatron_step_driver: a behavioural tube model reacts to the pulses and
// each move is scored against the shortest-path pulse count computed arithmetically.
module tb_dekatron_step_driver;
  localparam int PULSE_W   = 4;
  localparam int SETTLE_W  = 4;
  localparam int TIMEOUT   = 64;
  localparam int MAX_STEPS = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [9:0] target = 10'd0;
  logic [9:0] current = 10'd1;
  logic       ready = 1'b0;
  logic       pr_n, pl_n, busy, done, error;

  dekatron_step_driver #(
    .PULSE_W(PULSE_W), .SETTLE_W(SETTLE_W), .TIMEOUT(TIMEOUT), .MAX_STEPS(MAX_STEPS)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_target(target), .i_current(current), .i_ready(ready),
    .o_pulse_right_n(pr_n), .o_pulse_left_n(pl_n),
    .o_busy(busy), .o_done(done), .o_error(error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Tube model state
  int tube_pos = 0;
  bit force_ready_low = 0;
  int ready_lag = 0;
  int lag_left = 0;
  bit prev_r_low = 0, prev_l_low = 0;
  int run_len = 0;
  bit chk_width = 1;
  int n_right = 0, n_left = 0, n_done = 0;
  int cycle = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    total++;
    if (!pr_n && !pl_n) begin
      bad++;
      $display("FAIL both_low: right_n=%b left_n=%b, required never both 0", pr_n, pl_n);
    end
    if (done) n_done++;
    if (!pr_n || !pl_n) begin
      run_len++;
      if (!pr_n && !prev_r_low) n_right++;
      if (!pl_n && !prev_l_low) n_left++;
    end else if (prev_r_low || prev_l_low) begin
      if (chk_width) begin
        total++;
        if (run_len !== PULSE_W) begin
          bad++;
          $display("FAIL pulse_width: got %0d clocks, required %0d", run_len, PULSE_W);
        end
      end
      tube_pos = prev_r_low ? (tube_pos + 1) % 10 : (tube_pos + 9) % 10;
      run_len  = 0;
      lag_left = ready_lag;
    end else if (lag_left > 0) begin
      lag_left--;
    end
    prev_r_low = !pr_n;
    prev_l_low = !pl_n;
    current = 10'd1 << tube_pos;
    ready = pr_n && pl_n && (lag_left == 0) && !force_ready_low;
  endtask

  task automatic set_tube(input int p);
    tube_pos = p;
    current = 10'd1 << p;
    prev_r_low = 0;
    prev_l_low = 0;
    run_len = 0;
    lag_left = 0;
    ready = !force_ready_low;
    n_right = 0;
    n_left = 0;
    n_done = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (pr_n !== 1'b1)  begin bad++; $display("FAIL reset_right_n: got %b required 1", pr_n); end
    total++; if (pl_n !== 1'b1)  begin bad++; $display("FAIL reset_left_n: got %b required 1", pl_n); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done: got %b required 0", done); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b required 0", error); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_move(input int c, input int t, input int lag);
    int d, exp_r, exp_l, k;
    ready_lag = lag;
    set_tube(c);
    target = 10'd1 << t;
    start = 1'b1;
    tick();
    start = 1'b0;
    target = 10'($urandom);  // must be ignored: latched copy is used
    k = 0;
    while (!done && !error && k < 600) begin tick(); k++; end
    d = (t - c + 10) % 10;
    exp_r = (d <= 5) ? d : 0;
    exp_l = (d > 5) ? 10 - d : 0;
    $display("move %0d->%0d lag=%0d: right=%0d left=%0d done=%b error=%b", c, t, lag, n_right, n_left, done, error);
    total++; if (done !== 1'b1)    begin bad++; $display("FAIL move_done %0d->%0d: got %b required 1", c, t, done); end
    total++; if (error !== 1'b0)   begin bad++; $display("FAIL move_error %0d->%0d: got %b required 0", c, t, error); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL move_busy %0d->%0d: got %b required 0", c, t, busy); end
    total++; if (n_right !== exp_r) begin bad++; $display("FAIL move_right %0d->%0d: got %0d required %0d", c, t, n_right, exp_r); end
    total++; if (n_left !== exp_l)  begin bad++; $display("FAIL move_left %0d->%0d: got %0d required %0d", c, t, n_left, exp_l); end
    total++; if (tube_pos !== t)    begin bad++; $display("FAIL move_pos %0d->%0d: got %0d required %0d", c, t, tube_pos, t); end
    tick();
    total++; if (done !== 1'b0 || n_done !== 1) begin
      bad++; $display("FAIL move_strobe %0d->%0d: done=%b count=%0d required 0 and 1", c, t, done, n_done);
    end
  endtask

  task automatic test_directed();
    test_move(0, 3, 0);
    test_move(2, 8, 2);
    test_move(0, 5, 1);
    test_move(9, 0, 0);
    test_move(0, 9, 3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++)
      test_move($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 6));
  endtask

  task automatic test_already_there();
    int k;
    ready_lag = 0;
    set_tube(4);
    target = 10'd1 << 4;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 1;
    while (!done && k < 10) begin tick(); k++; end
    $display("already-at-target: done at tick %0d pulses=%0d", k, n_right + n_left);
    total++; if (k !== 3) begin bad++; $display("FAIL at_target_latency: got %0d required 3", k); end
    total++; if (n_right + n_left !== 0) begin bad++; $display("FAIL at_target_pulses: got %0d required 0", n_right + n_left); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL at_target_busy: got %b required 0", busy); end
    tick();
  endtask

  task automatic test_bad_target();
    logic [9:0] bad_t [2];
    int k;
    bad_t[0] = 10'b0000000000;
    bad_t[1] = 10'b0000010010;
    for (int i = 0; i < 2; i++) begin
      set_tube(2);
      target = bad_t[i];
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 1;
      while (!error && k < 10) begin tick(); k++; end
      $display("bad target %b: error=%b at tick %0d pulses=%0d", bad_t[i], error, k, n_right + n_left);
      total++; if (error !== 1'b1) begin bad++; $display("FAIL bad_target_error: got %b required 1", error); end
      total++; if (k !== 3) begin bad++; $display("FAIL bad_target_latency: got %0d required 3", k); end
      total++; if (n_right + n_left !== 0) begin bad++; $display("FAIL bad_target_pulses: got %0d required 0", n_right + n_left); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL bad_target_busy: got %b required 0", busy); end
      tick();
      total++; if (error !== 1'b1) begin bad++; $display("FAIL error_sticky: got %b required 1", error); end
    end
    target = 10'd1 << 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    $display("valid start after error: error=%b busy=%b", error, busy);
    total++; if (error !== 1'b0) begin bad++; $display("FAIL error_clear: got %b required 0", error); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL error_clear_busy: got %b required 1", busy); end
    k = 0;
    while (!done && k < 10) begin tick(); k++; end
    tick();
  endtask

  task automatic test_timeout();
    int k, rel, dt;
    force_ready_low = 1;
    ready_lag = 0;
    set_tube(1);
    target = 10'd1 << 5;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!(n_right == 1 && pr_n) && k < 20) begin tick(); k++; end
    rel = cycle;
    k = 0;
    while (!error && k < 200) begin tick(); k++; end
    dt = cycle - rel;
    $display("timeout: error=%b after %0d clocks from settle entry, pulses=%0d", error, dt, n_right + n_left);
    total++; if (error !== 1'b1) begin bad++; $display("FAIL timeout_error: got %b required 1", error); end
    total++; if (dt < TIMEOUT || dt > TIMEOUT + 1) begin bad++; $display("FAIL timeout_latency: got %0d required %0d..%0d", dt, TIMEOUT, TIMEOUT + 1); end
    total++; if (n_right !== 1 || n_left !== 0) begin bad++; $display("FAIL timeout_pulses: got right=%0d left=%0d required 1 and 0", n_right, n_left); end
    total++; if (busy !== 1'b0 || pr_n !== 1'b1 || pl_n !== 1'b1) begin
      bad++; $display("FAIL timeout_outputs: got busy=%b r=%b l=%b required 0 1 1", busy, pr_n, pl_n);
    end
    force_ready_low = 0;
    tick();
  endtask

  task automatic test_abort();
    int k;
    chk_width = 0;
    ready_lag = 0;
    set_tube(0);
    target = 10'd1 << 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (pr_n && k < 10) begin tick(); k++; end
    tick();
    total++; if (pr_n !== 1'b0) begin bad++; $display("FAIL abort_pulse_low: got %b required 0", pr_n); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    $display("abort in pulse: right_n=%b busy=%b", pr_n, busy);
    total++; if (pr_n !== 1'b1) begin bad++; $display("FAIL abort_pulse_high: got %b required 1", pr_n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b required 0", busy); end
    for (int i = 0; i < 20; i++) tick();
    total++; if (n_done !== 0) begin bad++; $display("FAIL abort_no_done: got %0d strobes required 0", n_done); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL abort_error: got %b required 0", error); end
    total++; if (n_right !== 1 || n_left !== 0) begin bad++; $display("FAIL abort_pulses: got right=%0d left=%0d required 1 and 0", n_right, n_left); end
    chk_width = 1;
  endtask

  task automatic test_reset_mid_settle();
    int k;
    ready_lag = 6;
    set_tube(0);
    target = 10'd1 << 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!(n_right == 1 && pr_n) && k < 20) begin tick(); k++; end
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL settle_busy: got %b required 1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    $display("reset mid-settle: r=%b l=%b busy=%b done=%b error=%b", pr_n, pl_n, busy, done, error);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL async_reset_busy: got %b required 0", busy); end
    total++; if (pr_n !== 1'b1 || pl_n !== 1'b1) begin bad++; $display("FAIL async_reset_pulses: got %b %b required 1 1", pr_n, pl_n); end
    total++; if (done !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL async_reset_flags: got done=%b error=%b required 0 0", done, error); end
    tick();
    rst_n = 1'b1;
    tick();
    ready_lag = 0;
  endtask

  task automatic test_back_to_back();
    int c, t, d, k, exp_r, exp_l;
    ready_lag = 1;
    set_tube($urandom_range(0, 9));
    for (int i = 0; i < 6; i++) begin
      c = tube_pos;
      t = $urandom_range(0, 9);
      n_right = 0;
      n_left = 0;
      target = 10'd1 << t;
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      while (!done && !error && k < 600) begin tick(); k++; end
      d = (t - c + 10) % 10;
      exp_r = (d <= 5) ? d : 0;
      exp_l = (d > 5) ? 10 - d : 0;
      $display("b2b %0d->%0d: right=%0d left=%0d done=%b", c, t, n_right, n_left, done);
      total++; if (done !== 1'b1 || tube_pos !== t) begin
        bad++; $display("FAIL b2b_reach %0d->%0d: got done=%b pos=%0d required 1 and %0d", c, t, done, tube_pos, t);
      end
      total++; if (n_right !== exp_r || n_left !== exp_l) begin
        bad++; $display("FAIL b2b_pulses %0d->%0d: got %0d/%0d required %0d/%0d", c, t, n_right, n_left, exp_r, exp_l);
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_already_there();
    test_bad_target();
    test_timeout();
    test_abort();
    test_reset_mid_settle();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
